// File: rtl/decoder_if.sv
// Decoder bus: polynomial RAM read ports, message RAM write port and start/done handshake.
interface decoder_if;
  localparam int unsigned AW = 9;
  localparam int unsigned CW = 16;
  localparam int unsigned MW = 3;
  localparam int unsigned WW = 32;

  logic          start;
  logic          done;
  logic [AW-1:0] poly_addra;
  logic [CW-1:0] poly_doa;
  logic [AW-1:0] poly_addrb;
  logic [CW-1:0] poly_dob;
  logic          msg_we;
  logic [MW-1:0] msg_addr;
  logic [0:WW-1] msg_di;

  modport slave (
    input  start, poly_doa, poly_dob,
    output done, poly_addra, poly_addrb, msg_we, msg_addr, msg_di
  );

  modport master (
    output start, poly_doa, poly_dob,
    input  done, poly_addra, poly_addrb, msg_we, msg_addr, msg_di
  );
endinterface

// File: rtl/decoder.sv
// NewHope message decoder: folds each coefficient pair (k, k+256) into one message bit
// and packs 256 bits into eight 32-bit words written to the message RAM.
module decoder #(
  parameter int unsigned NEWHOPE_HALF_Q = 6144
) (
  input  logic       clk,
  input  logic       rst,
  decoder_if.slave   bus
);
  localparam int unsigned KW = 8;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 17;
  localparam int unsigned SW = 18;
  localparam int unsigned WW = 32;
  localparam int unsigned MW = 3;
  localparam int unsigned PW = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [AW-1:0] addrb_q, addrb_d;
  logic          vld_q, vld_d;
  logic [KW-1:0] kd_q, kd_d;
  logic [0:WW-1] acc_q, acc_d;
  logic [0:WW-1] di_q, di_d;
  logic          we_q, we_d;
  logic [MW-1:0] maddr_q, maddr_d;
  logic          done_q, done_d;

  logic signed [DW-1:0] diff_a_c, diff_b_c;
  logic [DW-1:0]        da_c, db_c;
  logic [SW-1:0]        sum_c;
  logic                 bit_c;
  logic [PW-1:0]        pos_c;
  logic [KW-1:0]        k_next_c;

  // Distance of both coefficients from the centre; small total distance means bit 1.
  always_comb begin
    diff_a_c = $signed({1'b0, bus.poly_doa}) - $signed(DW'(NEWHOPE_HALF_Q));
    diff_b_c = $signed({1'b0, bus.poly_dob}) - $signed(DW'(NEWHOPE_HALF_Q));
    da_c     = diff_a_c[DW-1] ? DW'(-diff_a_c) : DW'(diff_a_c);
    db_c     = diff_b_c[DW-1] ? DW'(-diff_b_c) : DW'(diff_b_c);
    sum_c    = SW'(da_c) + SW'(db_c);
    bit_c    = (sum_c < SW'(NEWHOPE_HALF_Q));
    pos_c    = {kd_q[4:3], ~kd_q[2:0]};
    k_next_c = addra_q[KW-1:0] + KW'(1);
  end

  always_comb begin
    state_d = state_q;
    addra_d = '0;
    addrb_d = '0;
    vld_d   = (state_q == RUN);
    kd_d    = addra_q[KW-1:0];
    acc_d   = acc_q;
    di_d    = '0;
    we_d    = 1'b0;
    maddr_d = '0;
    done_d  = we_q && (maddr_q == '1);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          addrb_d = {1'b1, KW'(0)};
        end
      end
      RUN: begin
        if (addra_q[KW-1:0] == '1) begin
          state_d = DRAIN;
        end else begin
          addra_d = {1'b0, k_next_c};
          addrb_d = {1'b1, k_next_c};
        end
      end
      DRAIN: begin
        if (we_q && (maddr_q == '1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accumulate the returned bit; flush the word once its last bit is in.
    if (vld_q) begin
      acc_d[pos_c] = bit_c;
      if (kd_q[4:0] == '1) begin
        we_d    = 1'b1;
        maddr_d = kd_q[KW-1:KW-MW];
        di_d    = acc_d;
        acc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addra_q <= '0;
      addrb_q <= '0;
      vld_q   <= 1'b0;
      kd_q    <= '0;
      acc_q   <= '0;
      di_q    <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addra_q <= addra_d;
      addrb_q <= addrb_d;
      vld_q   <= vld_d;
      kd_q    <= kd_d;
      acc_q   <= acc_d;
      di_q    <= di_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      done_q  <= done_d;
    end
  end

  assign bus.poly_addra = addra_q;
  assign bus.poly_addrb = addrb_q;
  assign bus.msg_we     = we_q;
  assign bus.msg_addr   = maddr_q;
  assign bus.msg_di     = di_q;
  assign bus.done       = done_q;
endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter NEWHOPE_HALF_Q, default 6144: decision threshold, and centre subtracted from each coefficient.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (0 = reset); no other reset source.
REQ-004 start  in  1  one-cycle request to decode; sampled only in IDLE.
REQ-005 done  out  1  one-cycle pulse; message fully written.
REQ-006 poly_addra  out  9  read address, lower half-poly (coefficient k).
REQ-007 poly_doa  in  16  unsigned coefficient read at poly_addra; valid one cycle after address.
REQ-008 poly_addrb  out  9  read address, upper half-poly (k+256).
REQ-009 poly_dob  in  16  unsigned coefficient read at poly_addrb; one-cycle latency.
REQ-010 msg_we  out  1  message-RAM write enable.
REQ-011 msg_addr  out  3  message word address, 0..7.
REQ-012 msg_di  out  [0:31]  message word; index 0 is the MSB.

Function
REQ-013 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start=1; RUN->DRAIN after address k=255 is issued; DRAIN->IDLE after the final word write.
REQ-014 In RUN, k SHALL step 0..255, one per cycle; poly_addra=k, poly_addrb=k+256.
REQ-015 Outside RUN, poly_addra and poly_addrb SHALL be 0.
REQ-016 Per k, inputs a=poly_doa and b=poly_dob, sampled one cycle after address k:
- da=|a-HALF_Q|, db=|b-HALF_Q|.
- Compute in 17-bit signed.
- s=da+db, 18-bit unsigned, no saturation.
REQ-017 Bit(k) SHALL be 1 iff s < HALF_Q, else 0.
REQ-018 Bit(k) SHALL go to word k[7:5], position msg_di[k[4:3]*8 + 7 - k[2:0]].
REQ-019 Each word SHALL be written exactly once, in order 0..7:
- Write occurs the cycle after bit(32w+31) is computed.
- msg_we=1 for that one cycle only.
REQ-020 Start accepted at cycle T: address k SHALL be issued in cycle T+1+k and its bit registered at the end of cycle T+2+k.
REQ-021 Word w SHALL be written in cycle T+34+32w; the last write is in T+258; done=1 in T+259 only.
REQ-022 When msg_we=0, msg_di and msg_addr SHALL be 0.
REQ-023 start asserted in RUN or DRAIN SHALL be ignored, with no restart and no queuing.
REQ-024 start held high continuously SHALL begin a new decode in the cycle after return to IDLE.
REQ-025 Coefficients ≥ 12289 are not rejected; they SHALL follow REQ-016/017 arithmetic exactly.
REQ-026 Encoding a 32-byte message (value HALF_Q for bit=1, 0 for bit=0, both halves) then decoding SHALL reproduce the message bit-exactly.

Reset
REQ-027 While rst=0, the following SHALL be 0 immediately, independent of clk:
- outputs: done, msg_we, msg_addr, msg_di, poly_addra, poly_addrb;
- internal state: state=IDLE, k, pipeline valid, word accumulator.
REQ-028 Reset mid-decode SHALL abort with no further writes and no done pulse; words already written are not retracted.
REQ-029 After rst returns to 1, the block SHALL wait in IDLE for a new start.

Verification
REQ-030 All 512 coefficients = 6144, start at T -> 8 writes, addr 0..7, each msg_di=0xFFFFFFFF, in cycles T+34+32w; done in T+259 only.
REQ-031 All coefficients = 0 -> s=12288 -> 8 writes of 0x00000000; done asserted.
REQ-032 Threshold, all other coefficients 0:
- k=0 pair (6144,12287) gives s=6143, bit 1.
- k=1 pair (6144,12288) gives s=6144, bit 0.
- k=2 pair (3072,3073) gives s=6143, bit 1.
- Expected word 0 = 0x05000000 (positions 5 and 7).
REQ-033 Bit order: only k=9 pair = (6144,6144), rest 0 -> word 0 = 0x00020000 (position 14); words 1..7 = 0.
REQ-034 rst=0 asynchronously at cycle T+100 -> all outputs 0 at once; no further msg_we, no done. A new start after release -> full 8-word decode.
REQ-035 start pulsed at T+50 during RUN -> ignored; exactly 8 writes, one done pulse. Random-message encode/decode round trip -> message identical.
